pconv_accum_unit: RTL and testbench

Parametrised successor of the fixed 6-lane partial-convolution unit. It computes a dot product of CH lanes per beat through a pipelined multiplier stage and adder tree. Products are accumulated across multiple input-channel-group beats until a last-beat marker arrives, then the block applies bias, arithmetic shift, ReLU and saturation to produce one N-bit activation. It sits between the feature/weight buffers and the layer output buffer in each conv layer.

---
 rtl/pconv_accum_unit.sv | 172 +++++++++++++++++
 tb/tb_pconv_accum_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pconv_accum_unit.sv
// pconv_accum_unit: pipelined CH-lane dot product with multi-beat accumulation,
// followed by bias add, arithmetic right shift, ReLU and saturation to N bits.
// Optional build macro PCONV_ROUND_EN: round half up before the shift instead
// of plain floor shifting.

// Per-lane signed multiplier, product sign-extended to the accumulator width.
module pconv_lane_mul #(
  parameter int N     = 16,
  parameter int ACC_W = 32
) (
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_i,
  output logic signed [ACC_W-1:0] p_o
);
  logic signed [2*N-1:0] prod;
  assign prod = a_i * b_i;
  assign p_o  = ACC_W'(prod);
endmodule

module pconv_accum_unit #(
  parameter int N     = 16,
  parameter int CH    = 6,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_vld,
  input  logic              in_last,
  input  logic [CH*N-1:0]   input_din,
  input  logic [CH*N-1:0]   weight_din,
  input  logic [ACC_W-1:0]  bias_din,
  input  logic [4:0]        shift_din,
  output logic [N-1:0]      conv_dout,
  output logic              conv_dout_vld
);
  localparam int TL = $clog2(CH);

  // number of live partial sums at tree level l
  function automatic int lvl_cnt(input int l);
    return (CH + (1 << l) - 1) >> l;
  endfunction

  logic signed [ACC_W-1:0] prod [CH];

  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_lane
      pconv_lane_mul #(.N(N), .ACC_W(ACC_W)) u_mul (
        .a_i (input_din[g*N +: N]),
        .b_i (weight_din[g*N +: N]),
        .p_o (prod[g])
      );
    end
  endgenerate

  // Level 0 holds the registered products; level TL holds the final tree sum.
  // Arrays are 2*CH wide so the pairwise index 2j+1 is always in range; the
  // upper half is never written and stays zero.
  logic signed [ACC_W-1:0] tree_q      [TL+1][2*CH];
  logic [TL:0]             vld_pipe_q;
  logic [TL:0]             last_pipe_q;
  logic [ACC_W-1:0]        bias_pipe_q [TL+1];
  logic [4:0]              shift_pipe_q[TL+1];

  // Multiplier stage and adder tree, sideband travelling alongside each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      for (int l = 0; l <= TL; l++) begin
        bias_pipe_q[l]  <= '0;
        shift_pipe_q[l] <= '0;
        for (int j = 0; j < 2*CH; j++) tree_q[l][j] <= '0;
      end
    end else if (ce) begin
      vld_pipe_q[0]   <= in_vld;
      last_pipe_q[0]  <= in_vld & in_last;
      bias_pipe_q[0]  <= bias_din;
      shift_pipe_q[0] <= shift_din;
      for (int j = 0; j < CH; j++) tree_q[0][j] <= prod[j];
      for (int l = 1; l <= TL; l++) begin
        vld_pipe_q[l]   <= vld_pipe_q[l-1];
        last_pipe_q[l]  <= last_pipe_q[l-1];
        bias_pipe_q[l]  <= bias_pipe_q[l-1];
        shift_pipe_q[l] <= shift_pipe_q[l-1];
        for (int j = 0; j < CH; j++) begin
          if (j < lvl_cnt(l)) begin
            if (2*j+1 < lvl_cnt(l-1))
              tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
            else
              tree_q[l][j] <= tree_q[l-1][2*j];
          end else begin
            tree_q[l][j] <= '0;
          end
        end
      end
    end
  end

  // Accumulate stage: a valid beat either starts or extends the running sum.
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic                    a_last_q;
  logic [ACC_W-1:0]        a_bias_q;
  logic [4:0]              a_shift_q;

  // Bubbles leave the accumulator and first-beat flag untouched.
  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (vld_pipe_q[TL]) begin
      acc_d   = (first_q ? '0 : acc_q) + tree_q[TL][0];
      first_d = last_pipe_q[TL];
    end
  end

  // Accumulator register plus the last-beat sideband for the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      a_last_q  <= 1'b0;
      a_bias_q  <= '0;
      a_shift_q <= '0;
    end else if (ce) begin
      acc_q     <= acc_d;
      first_q   <= first_d;
      a_last_q  <= vld_pipe_q[TL] & last_pipe_q[TL];
      a_bias_q  <= bias_pipe_q[TL];
      a_shift_q <= shift_pipe_q[TL];
    end
  end

  // Output stage: bias, shift, ReLU and saturation of the finished sum.
  logic signed [ACC_W-1:0] sum_w, res_w;
  logic [N-1:0]            conv_dout_q, conv_dout_d;
  logic                    conv_dout_vld_q;

  // Shaping of the completed pixel; output holds between pixels.
  always_comb begin
    sum_w = acc_q + $signed(a_bias_q);
`ifdef PCONV_ROUND_EN
    if (a_shift_q != 5'd0)
      sum_w = sum_w + $signed(ACC_W'(1) << (a_shift_q - 5'd1));
`endif
    res_w       = sum_w >>> a_shift_q;
    conv_dout_d = conv_dout_q;
    if (a_last_q) begin
      if (res_w < 0)
        conv_dout_d = '0;
      else if (res_w > $signed(ACC_W'({(N-1){1'b1}})))
        conv_dout_d = {1'b0, {(N-1){1'b1}}};
      else
        conv_dout_d = res_w[N-1:0];
    end
  end

  // Output registers; the valid pulse follows the last beat by one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_dout_q     <= '0;
      conv_dout_vld_q <= 1'b0;
    end else if (ce) begin
      conv_dout_q     <= conv_dout_d;
      conv_dout_vld_q <= a_last_q;
    end
  end

  assign conv_dout     = conv_dout_q;
  assign conv_dout_vld = conv_dout_vld_q;
endmodule

// File: tb/tb_pconv_accum_unit.sv
// Randomized + directed bench for pconv_accum_unit (N=16, CH=6, ACC_W=32).
module tb_pconv_accum_unit;
  localparam int N = 16, CH = 6, ACC_W = 32, TL = 3;

  logic              clk = 1'b0;
  logic              rst, ce, in_vld, in_last;
  logic [CH*N-1:0]   input_din, weight_din;
  logic [ACC_W-1:0]  bias_din;
  logic [4:0]        shift_din;
  logic [N-1:0]      conv_dout;
  logic              conv_dout_vld;

  always #5 clk = ~clk;

  pconv_accum_unit #(.N(N), .CH(CH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .in_last(in_last),
    .input_din(input_din), .weight_din(weight_din), .bias_din(bias_din),
    .shift_din(shift_din), .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: pixel sum and pending outputs keyed by the
  // enabled-cycle index at which they must appear.
  typedef struct { int due; int val; } exp_t;
  exp_t   q[$];
  int     a_v[CH], w_v[CH];
  longint macc;
  bit     mfirst;
  int     ecyc = 0;
  bit     last_en = 0;
  int     last_val = 0;
  bit     prev_vld = 0;
  int     ovr = -1;

  function automatic longint wrap(input longint x);
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
  endfunction

  function automatic int ref_act(input longint s, input int sh);
    longint r;
    r = wrap(s);
`ifdef PCONV_ROUND_EN
    if (sh > 0) r = wrap(r + (longint'(1) << (sh - 1)));
`endif
    r = r >>> sh;
    if (r < 0) return 0;
    if (r > 32767) return 32767;
    return int'(r);
  endfunction

  task automatic set_lanes(input int a, input int w);
    for (int i = 0; i < CH; i++) begin a_v[i] = a; w_v[i] = w; end
  endtask

  // One cycle of stimulus; the model only advances on beats the DUT accepts.
  task automatic send(input bit v, input bit l, input longint bias, input int sh, input bit cev);
    longint dot;
    exp_t   e;
    logic [63:0] bb;
    logic [31:0] ss;
    @(posedge clk); #1;
    bb = bias; ss = sh;
    ce = cev; in_vld = v; in_last = l;
    for (int i = 0; i < CH; i++) begin
      input_din[i*N +: N]  = N'(a_v[i]);
      weight_din[i*N +: N] = N'(w_v[i]);
    end
    bias_din  = bb[31:0];
    shift_din = ss[4:0];
    if (cev && v) begin
      dot = 0;
      for (int i = 0; i < CH; i++) dot += longint'(a_v[i]) * w_v[i];
      macc   = wrap((mfirst ? 0 : macc) + dot);
      mfirst = l;
      if (l) begin
        e.due = ecyc + 1 + TL + 2;
        e.val = (ovr >= 0) ? ovr : ref_act(macc + bias, sh);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_vld = 1'b0;
    q.delete(); mfirst = 1; macc = 0; last_val = 0; prev_vld = 0;
    #2;
    chk("rst_dout", conv_dout, 0);
    chk("rst_vld", conv_dout_vld, 0);
    @(posedge clk); #1;
    chk("rst_dout_hold", conv_dout, 0);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    last_en = !rst && ce;
    if (last_en) ecyc++;
  end

  // Output monitor: pulse exactly on the due cycle, silence otherwise,
  // everything frozen while ce is low, and dout holding between pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (last_en) begin
        if (q.size() > 0 && q[0].due == ecyc) begin
          chk("vld_pulse", conv_dout_vld, 1);
          last_val = q[0].val;
          void'(q.pop_front());
          prev_vld = 1;
        end else begin
          chk("vld_idle", conv_dout_vld, 0);
          prev_vld = 0;
        end
      end else begin
        chk("vld_hold", conv_dout_vld, prev_vld);
      end
      chk("dout", conv_dout, last_val);
    end
  end

  initial begin
    int nb;
    rst = 1'b1; ce = 1'b0; in_vld = 1'b0; in_last = 1'b0;
    input_din = '0; weight_din = '0; bias_din = '0; shift_din = '0;
    mfirst = 1; macc = 0;
    set_lanes(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", conv_dout, 0);
    chk("reset_vld", conv_dout_vld, 0);
    rst = 1'b0;
    idle(2);

    // basic dot product, then the rounding-sensitive bias
    set_lanes(2, 3);
    ovr = 20; send(1, 1, 4, 1, 1); idle(8);
`ifdef PCONV_ROUND_EN
    ovr = 21;
`else
    ovr = 20;
`endif
    send(1, 1, 5, 1, 1); idle(8);

    // three beats with a bubble
    set_lanes(1, 1);
    ovr = 18;
    send(1, 0, 0, 0, 1); send(0, 0, 0, 0, 1);
    send(1, 0, 0, 0, 1); send(1, 1, 0, 0, 1); idle(8);

    // ReLU then back-to-back pixel
    set_lanes(5, -1); ovr = 0; send(1, 1, 0, 0, 1);
    set_lanes(1, 1);  ovr = 6; send(1, 1, 0, 0, 1); idle(8);

    // saturation and large shift
    set_lanes(16384, 16384);
    ovr = 32767; send(1, 1, 0, 0, 1);
    ovr = 1536;  send(1, 1, 0, 20, 1); idle(8);

    // ce stall while in flight; junk on inputs is ignored
    set_lanes(2, 3); ovr = 20; send(1, 1, 4, 1, 1);
    idle(2);
    for (int i = 0; i < 3; i++) send(1, 1, 99, 3, 0);
    idle(8);

    // reset mid-pixel
    set_lanes(2, 3); ovr = -1;
    send(1, 0, 0, 0, 1); send(1, 0, 0, 0, 1);
    do_reset();
    set_lanes(1, 2); ovr = 12; send(1, 1, 0, 0, 1); idle(8);

    // randomized pixels with bubbles and ce stalls
    ovr = -1;
    for (int p = 0; p < 300; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < CH; i++) begin
          if (p % 2 == 0) begin
            a_v[i] = $urandom_range(0, 16) - 8;
            w_v[i] = $urandom_range(0, 16) - 8;
          end else begin
            a_v[i] = $urandom_range(0, 65535) - 32768;
            w_v[i] = $urandom_range(0, 65535) - 32768;
          end
        end
        if ($urandom_range(0, 3) == 0) send(0, 1, 7, 2, 1);
        if ($urandom_range(0, 5) == 0) send(1, 1, 3, 1, 0);
        send(1, b == nb - 1,
             (p % 2 == 0) ? longint'($urandom_range(0, 64)) - 32 : longint'(int'($urandom())),
             $urandom_range(0, 31) > 24 ? $urandom_range(0, 31) : $urandom_range(0, 4), 1);
      end
    end
    idle(12);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
